axi_wr_master: RTL and testbench
================================

Name: axi_wr_master

Overview:
- Write-data transmitter for the W channel: the initiator end that drives the burst a write-data slave consumes.
- A `key` pulse starts one burst of `data_len` 32-bit beats with incrementing payload.
- Uses VALID/READY handshake; WLAST marks the final beat.
- Sits beside the slave in the bus test fabric; its outputs connect directly to the slave's S_W* inputs.

Parameters:
- data_len, 256, beats per burst (≥1).
- DATA_BASE, 32'h0000_0000, payload of beat 0; beat i carries DATA_BASE+i, mod 2^32.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- key  input  1  burst start, sampled each rising edge.
- M_WREADY  input  1  slave ready.
- M_WVALID  output  1  beat valid.
- M_WDATA  output  32  beat payload.
- M_WLAST  output  1  final beat of burst.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Single clock clk; asynchronous active-low reset rstn. While rstn=0, all outputs are 0, the beat counter is 0 and the state is IDLE. All outputs are registered.
- Beat counter: $clog2(data_len)+1 bits, internal.
- Transfer rule: a beat transfers on a rising edge where M_WVALID=1 and M_WREADY=1.
- While M_WVALID=1 and no transfer occurs, M_WDATA and M_WLAST hold stable.
- M_WVALID never drops until its beat transfers.
- States:
  - IDLE: busy=0, M_WVALID=0. If key=1 at an edge, go to SEND with M_WVALID=1, M_WDATA=DATA_BASE, beat counter=0, M_WLAST=(data_len==1), busy=1. Start-to-first-valid latency is 1 cycle.
  - SEND, transfer of a non-last beat: increment the counter; M_WDATA<=M_WDATA+1 (32-bit wrap); M_WLAST<=(new index==data_len-1); M_WVALID stays 1. Back-to-back beats with M_WREADY held high.
  - SEND, transfer of the last beat (M_WLAST=1): go to DONE; M_WVALID, M_WLAST and M_WDATA go to 0; busy stays 1.
  - DONE: done=1 for exactly one cycle, busy=0 at the next edge; return to IDLE.
- key while in SEND or DONE is ignored; there is no queuing.
- key in IDLE on the cycle after DONE starts a new burst normally.
- M_WREADY may be high before M_WVALID; this is legal and causes no transfer until M_WVALID=1.
- M_WREADY dropping mid-burst stalls the burst indefinitely; no timeout.
- Minimum burst duration with M_WREADY tied high: data_len cycles of valid, plus 1 DONE cycle.
- rstn asserted mid-burst aborts immediately: outputs go to 0 asynchronously. The next key restarts from DATA_BASE.

Decomposition:
- Shared package `axi_pkg`:
  - AXI_DW=32.
  - FSM state encodings IDLE=2'd0, SEND=2'd1, DONE=2'd2, as localparams reused by slave-side FSMs.
- No sub-module: FSM, counter and data register fit in a single module (~150 lines).

Test Plan:
- data_len=4, DATA_BASE=32'h100, M_WREADY tied 1, key pulse → M_WDATA 0x100,0x101,0x102,0x103 on 4 consecutive cycles; M_WLAST only with 0x103; done=1 on the following cycle; busy high from key+1 through the DONE cycle.
- Same config, M_WREADY low for the first 5 cycles after key → M_WVALID=1 with 0x100 held stable for all 5 cycles; then the 4 beats complete; exactly 4 transfers counted.
- M_WREADY toggling 1,0,1,0 during a burst → payload held on each stall; the bench scoreboard sees 0x100..0x103 in order with no duplicates or gaps.
- data_len=1, DATA_BASE=32'hFFFF_FFFE → single beat 0xFFFFFFFE with M_WLAST=1. Separately, data_len=4 → 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1 (wrap).
- key pulsed again at beat 2 → ignored; only 4 beats. key on the cycle after done → a second identical burst starts.
- rstn pulled low after beat 1 transfers → M_WVALID/M_WLAST/busy=0 immediately. Release, then key → burst restarts at DATA_BASE.

Source files
------------

// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared definitions for the bus test fabric: the data-bus width and the
// three-state handshake FSM encoding used by the master and slave FSMs.
// ---------------------------------------------------------------------------
package axi_pkg;

    localparam int AXI_DW = 32;

    // FSM state encodings, shared with slave-side FSMs.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage : axi_pkg

// File: rtl/axi_wr_master.sv
// ---------------------------------------------------------------------------
// axi_wr_master
// W-channel write-data transmitter. A key pulse in IDLE starts one burst of
// data_len beats carrying DATA_BASE, DATA_BASE+1, ... (32-bit wrap). Beats
// move on VALID/READY handshakes; M_WLAST flags the final beat. After the
// last beat is accepted, done pulses for one cycle and the block returns to
// IDLE. Every output is registered.
//
// Ports:
//   clk       in   system clock, rising edge
//   rstn      in   asynchronous active-low reset
//   key       in   burst start, sampled each rising edge (IDLE only)
//   M_WREADY  in   slave ready
//   M_WVALID  out  beat valid
//   M_WDATA   out  beat payload (AXI_DW bits)
//   M_WLAST   out  final beat of the burst
//   busy      out  burst in progress (SEND and DONE states)
//   done      out  one-cycle pulse after the last beat is accepted
// ---------------------------------------------------------------------------
module axi_wr_master
    import axi_pkg::*;
#(
    parameter int          data_len  = 256,
    parameter logic [31:0] DATA_BASE = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              key,
    input  logic              M_WREADY,
    output logic              M_WVALID,
    output logic [AXI_DW-1:0] M_WDATA,
    output logic              M_WLAST,
    output logic              busy,
    output logic              done
);

    // One spare bit keeps the counter width sane when data_len is a power
    // of two and still gives a 1-bit counter when data_len == 1.
    localparam int            CW       = $clog2(data_len) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(data_len - 1);
    localparam logic          SINGLE   = (data_len == 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          xfer;

    assign xfer    = M_WVALID && M_WREADY;
    assign cnt_nxt = cnt + CW'(1);

    // NOTE: all state and outputs update with non-blocking assignments so
    // every register samples pre-edge values and the block order is irrelevant.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            M_WVALID <= 1'b0;
            M_WDATA  <= '0;
            M_WLAST  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (key) begin
                        state    <= SEND;
                        cnt      <= '0;
                        M_WVALID <= 1'b1;
                        M_WDATA  <= DATA_BASE;
                        M_WLAST  <= SINGLE;
                        busy     <= 1'b1;
                    end
                end

                SEND: begin
                    // Without a handshake everything holds, so VALID cannot
                    // drop and DATA/LAST stay stable across stalls.
                    if (xfer) begin
                        if (M_WLAST) begin
                            state    <= DONE;
                            M_WVALID <= 1'b0;
                            M_WDATA  <= '0;
                            M_WLAST  <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            cnt     <= cnt_nxt;
                            M_WDATA <= M_WDATA + 32'd1;
                            M_WLAST <= (cnt_nxt == LAST_IDX);
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    M_WVALID <= 1'b0;
                    M_WDATA  <= '0;
                    M_WLAST  <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule : axi_wr_master

// File: tb/tb_axi_wr_master.sv
// ---------------------------------------------------------------------------
// tb_axi_wr_master
// Three instances share clk/rstn:
//   u_a : data_len=4, DATA_BASE=0x100        (main burst / stall / key tests)
//   u_b : data_len=1, DATA_BASE=0xFFFFFFFE   (single-beat burst)
//   u_c : data_len=4, DATA_BASE=0xFFFFFFFE   (payload wrap)
// A negedge monitor records every handshake as {last, data} per instance.
// ---------------------------------------------------------------------------
module tb_axi_wr_master;

    logic clk;
    logic rstn;

    logic        key_a, ready_a, valid_a, last_a, busy_a, done_a;
    logic [31:0] data_a;
    logic        key_b, ready_b, valid_b, last_b, busy_b, done_b;
    logic [31:0] data_b;
    logic        key_c, ready_c, valid_c, last_c, busy_c, done_c;
    logic [31:0] data_c;

    logic [32:0] q_a[$];
    logic [32:0] q_b[$];
    logic [32:0] q_c[$];

    int errors = 0;
    int checks = 0;

    axi_wr_master #(.data_len(4), .DATA_BASE(32'h0000_0100)) u_a (
        .clk(clk), .rstn(rstn), .key(key_a), .M_WREADY(ready_a),
        .M_WVALID(valid_a), .M_WDATA(data_a), .M_WLAST(last_a),
        .busy(busy_a), .done(done_a)
    );

    axi_wr_master #(.data_len(1), .DATA_BASE(32'hFFFF_FFFE)) u_b (
        .clk(clk), .rstn(rstn), .key(key_b), .M_WREADY(ready_b),
        .M_WVALID(valid_b), .M_WDATA(data_b), .M_WLAST(last_b),
        .busy(busy_b), .done(done_b)
    );

    axi_wr_master #(.data_len(4), .DATA_BASE(32'hFFFF_FFFE)) u_c (
        .clk(clk), .rstn(rstn), .key(key_c), .M_WREADY(ready_c),
        .M_WVALID(valid_c), .M_WDATA(data_c), .M_WLAST(last_c),
        .busy(busy_c), .done(done_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change only at posedge+1, so a handshake seen at the negedge
    // is the one that completes on the following rising edge.
    always @(negedge clk) begin
        if (rstn) begin
            if (valid_a && ready_a) q_a.push_back({last_a, data_a});
            if (valid_b && ready_b) q_b.push_back({last_b, data_b});
            if (valid_c && ready_c) q_c.push_back({last_c, data_c});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the caller just after the edge that sampled key (first beat valid).
    task automatic pulse_key_a();
        key_a = 1'b1;
        step();
        key_a = 1'b0;
    endtask

    task automatic wait_done_a(input int budget, output bit seen);
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            if (done_a) seen = 1'b1;
            else step();
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        key_a = 0; key_b = 0; key_c = 0;
        ready_a = 0; ready_b = 0; ready_c = 0;
        #12;
        checks++;
        if ({valid_a, last_a, busy_a, done_a, data_a} !== 36'd0) begin
            errors++;
            $display("FAIL reset_a: got v%b l%b b%b d%b data=%h, want all 0",
                     valid_a, last_a, busy_a, done_a, data_a);
        end
        checks++;
        if ({valid_b, last_b, busy_b, done_b, data_b} !== 36'd0) begin
            errors++;
            $display("FAIL reset_b: got v%b l%b b%b d%b data=%h, want all 0",
                     valid_b, last_b, busy_b, done_b, data_b);
        end
        checks++;
        if ({valid_c, last_c, busy_c, done_c, data_c} !== 36'd0) begin
            errors++;
            $display("FAIL reset_c: got v%b l%b b%b d%b data=%h, want all 0",
                     valid_c, last_c, busy_c, done_c, data_c);
        end
        @(negedge clk);
        rstn = 1'b1;
        step();
        checks++;
        if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got valid=%b busy=%b, want 0 0", valid_a, busy_a);
        end
    endtask

    task automatic test_basic_burst();
        ready_a = 1'b1;
        q_a.delete();
        pulse_key_a();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (valid_a !== 1'b1 || data_a !== 32'h100 + i || last_a !== (i == 3) || busy_a !== 1'b1) begin
                errors++;
                $display("FAIL basic_beat%0d: got v%b data=%h l%b b%b, want v1 data=%h l%b b1",
                         i, valid_a, data_a, last_a, busy_a, 32'h100 + i, (i == 3));
            end
            step();
        end
        checks++;
        if (valid_a !== 1'b0 || done_a !== 1'b1 || busy_a !== 1'b1 || data_a !== 32'd0) begin
            errors++;
            $display("FAIL basic_done: got v%b d%b b%b data=%h, want v0 d1 b1 data=0",
                     valid_a, done_a, busy_a, data_a);
        end
        step();
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: got done=%b busy=%b, want 0 0", done_a, busy_a);
        end
        checks++;
        if (q_a.size() != 4) begin
            errors++;
            $display("FAIL basic_count: got %0d transfers, want 4", q_a.size());
        end
    endtask

    task automatic test_stall();
        bit seen;
        ready_a = 1'b0;
        q_a.delete();
        pulse_key_a();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (valid_a !== 1'b1 || data_a !== 32'h100 || last_a !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: got v%b data=%h l%b, want v1 data=00000100 l0",
                         i, valid_a, data_a, last_a);
            end
            step();
        end
        ready_a = 1'b1;
        wait_done_a(20, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL stall_done: got no done within 20 cycles, want done");
        end
        checks++;
        if (q_a.size() != 4) begin
            errors++;
            $display("FAIL stall_count: got %0d transfers, want 4", q_a.size());
        end
        step();
    endtask

    task automatic test_toggle_ready();
        bit seen;
        bit held;
        logic [31:0] hd;
        q_a.delete();
        ready_a = 1'b1;
        pulse_key_a();
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            if (done_a) begin
                seen = 1'b1;
            end else begin
                held = valid_a && !ready_a;
                hd   = data_a;
                step();
                if (held) begin
                    checks++;
                    if (valid_a !== 1'b1 || data_a !== hd) begin
                        errors++;
                        $display("FAIL toggle_hold: got v%b data=%h, want v1 data=%h", valid_a, data_a, hd);
                    end
                end
                ready_a = ~ready_a;
            end
        end
        ready_a = 1'b1;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL toggle_done: got no done within 40 cycles, want done");
        end
        checks++;
        if (q_a.size() != 4) begin
            errors++;
            $display("FAIL toggle_count: got %0d transfers, want 4", q_a.size());
        end
        for (int i = 0; i < 4 && i < q_a.size(); i++) begin
            checks++;
            if (q_a[i] !== {(i == 3), 32'h100 + i}) begin
                errors++;
                $display("FAIL toggle_order%0d: got %h, want %h", i, q_a[i], {(i == 3), 32'h100 + i});
            end
        end
        step();
    endtask

    task automatic test_single_and_wrap();
        logic [31:0] exp_c[4];
        exp_c[0] = 32'hFFFF_FFFE; exp_c[1] = 32'hFFFF_FFFF;
        exp_c[2] = 32'h0000_0000; exp_c[3] = 32'h0000_0001;
        q_b.delete();
        q_c.delete();
        ready_b = 1'b1;
        ready_c = 1'b1;
        key_b = 1'b1;
        key_c = 1'b1;
        step();
        key_b = 1'b0;
        key_c = 1'b0;
        checks++;
        if (valid_b !== 1'b1 || data_b !== 32'hFFFF_FFFE || last_b !== 1'b1) begin
            errors++;
            $display("FAIL single_beat: got v%b data=%h l%b, want v1 data=fffffffe l1", valid_b, data_b, last_b);
        end
        step();
        checks++;
        if (valid_b !== 1'b0 || done_b !== 1'b1 || busy_b !== 1'b1) begin
            errors++;
            $display("FAIL single_done: got v%b d%b b%b, want v0 d1 b1", valid_b, done_b, busy_b);
        end
        step();
        step();
        step();
        checks++;
        if (done_c !== 1'b1) begin
            errors++;
            $display("FAIL wrap_done: got done=%b, want 1", done_c);
        end
        checks++;
        if (q_b.size() != 1 || q_c.size() != 4) begin
            errors++;
            $display("FAIL wrap_count: got b=%0d c=%0d transfers, want 1 and 4", q_b.size(), q_c.size());
        end
        for (int i = 0; i < 4 && i < q_c.size(); i++) begin
            checks++;
            if (q_c[i] !== {(i == 3), exp_c[i]}) begin
                errors++;
                $display("FAIL wrap_beat%0d: got %h, want %h", i, q_c[i], {(i == 3), exp_c[i]});
            end
        end
        step();
    endtask

    task automatic test_key_ignored();
        ready_a = 1'b1;
        q_a.delete();
        pulse_key_a();
        step();
        step();
        // Beat 2 on the bus: key now must not restart or queue anything.
        key_a = 1'b1;
        step();
        key_a = 1'b0;
        step();
        checks++;
        if (done_a !== 1'b1) begin
            errors++;
            $display("FAIL ignore_done: got done=%b, want 1", done_a);
        end
        key_a = 1'b1;
        step();
        key_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
                errors++;
                $display("FAIL ignore_idle%0d: got v%b b%b, want 0 0", i, valid_a, busy_a);
            end
            step();
        end
        checks++;
        if (q_a.size() != 4) begin
            errors++;
            $display("FAIL ignore_count: got %0d transfers, want 4", q_a.size());
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        ready_a = 1'b1;
        q_a.delete();
        pulse_key_a();
        step(); step(); step(); step();
        step();
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: got done=%b busy=%b, want 0 0", done_a, busy_a);
        end
        pulse_key_a();
        checks++;
        if (valid_a !== 1'b1 || data_a !== 32'h100 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: got v%b data=%h b%b, want v1 data=00000100 b1", valid_a, data_a, busy_a);
        end
        wait_done_a(10, seen);
        checks++;
        if (!seen || q_a.size() != 8) begin
            errors++;
            $display("FAIL b2b_count: got done_seen=%0d transfers=%0d, want 1 and 8", seen, q_a.size());
        end
        for (int i = 0; i < 8 && i < q_a.size(); i++) begin
            checks++;
            if (q_a[i] !== {((i % 4) == 3), 32'h100 + (i % 4)}) begin
                errors++;
                $display("FAIL b2b_beat%0d: got %h, want %h", i, q_a[i], {((i % 4) == 3), 32'h100 + (i % 4)});
            end
        end
        step();
    endtask

    task automatic test_reset_abort();
        bit seen;
        ready_a = 1'b1;
        q_a.delete();
        pulse_key_a();
        step();
        step();
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (valid_a !== 1'b0 || last_a !== 1'b0 || busy_a !== 1'b0 || data_a !== 32'd0) begin
            errors++;
            $display("FAIL abort_async: got v%b l%b b%b data=%h, want all 0", valid_a, last_a, busy_a, data_a);
        end
        @(negedge clk);
        rstn = 1'b1;
        step();
        checks++;
        if (valid_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got valid=%b, want 0", valid_a);
        end
        q_a.delete();
        pulse_key_a();
        checks++;
        if (valid_a !== 1'b1 || data_a !== 32'h100) begin
            errors++;
            $display("FAIL abort_restart: got v%b data=%h, want v1 data=00000100", valid_a, data_a);
        end
        wait_done_a(10, seen);
        checks++;
        if (!seen || q_a.size() != 4) begin
            errors++;
            $display("FAIL abort_count: got done_seen=%0d transfers=%0d, want 1 and 4", seen, q_a.size());
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_stall();
        test_toggle_ready();
        test_single_and_wrap();
        test_key_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_axi_wr_master
